// File: rtl/bus_booking_pkg.sv
// Shared state encoding and helpers for the bus booking flow controller.
package bus_booking_pkg;

   localparam int unsigned STATE_W = 4;

   typedef enum logic [STATE_W-1:0] {
      S_IDLE        = 4'd0,
      S_OPEN_APP    = 4'd1,
      S_LOCATION    = 4'd2,
      S_FILTER      = 4'd3,
      S_SELECT_BUS  = 4'd4,
      S_SELECT_SEAT = 4'd5,
      S_BOARDING    = 4'd6,
      S_COUPON      = 4'd7,
      S_PAYMENT     = 4'd8,
      S_DONE        = 4'd9,
      S_ABORT       = 4'd10
   } state_t;

   // True for the steps where the user is mid-booking and the inactivity timer runs.
   function automatic logic is_active(state_t s);
      return (s >= S_OPEN_APP) && (s <= S_PAYMENT);
   endfunction

endpackage

// File: rtl/bus_booking_ctrl_if.sv
// User-input / back-end facing signal bundle of the booking controller.
interface bus_booking_ctrl_if #(
   parameter int unsigned SEAT_W = 4
);
   import bus_booking_pkg::*;

   logic              nxt;
   logic              back;
   logic              cancel;
   logic [SEAT_W-1:0] seat_req;
   logic [SEAT_W-1:0] seats_avail;
   logic              pay_ok;
   logic              pay_fail;
   state_t            state;
   logic              busy;
   logic [SEAT_W-1:0] seats_booked;
   logic              seat_err;
   logic              booked;
   logic              aborted;

   modport master (
      output nxt, back, cancel, seat_req, seats_avail, pay_ok, pay_fail,
      input  state, busy, seats_booked, seat_err, booked, aborted
   );

   modport slave (
      input  nxt, back, cancel, seat_req, seats_avail, pay_ok, pay_fail,
      output state, busy, seats_booked, seat_err, booked, aborted
   );

endinterface

// File: rtl/bus_booking_ctrl_timer.sv
// Per-step inactivity counter; expired flags the last idle cycle before a forced abort.
module booking_timer #(
   parameter int unsigned TIMEOUT_CYC = 1000
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC);

   logic [CNT_W-1:0] cnt;

   assign expired = (cnt == CNT_W'(TIMEOUT_CYC - 1));

   // Saturates at the terminal count so it never wraps while the abort is pending.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt <= '0;
      end else if (en && !expired) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/bus_booking_ctrl.sv
// Booking-flow controller: steps the user through seat selection and payment with
// back/cancel, inactivity timeout, seat validation and bounded payment retries.
module bus_booking_ctrl
   import bus_booking_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYC = 1000,
   parameter int unsigned MAX_SEATS   = 6,
   parameter int unsigned SEAT_W      = 4,
   parameter int unsigned MAX_RETRY   = 3
) (
   input logic               clk,
   input logic               rst,
   bus_booking_ctrl_if.slave bif
);

   localparam int unsigned RETRY_W = $clog2(MAX_RETRY + 1);

   state_t              state, state_nxt;
   logic [RETRY_W-1:0]  retry, retry_nxt, retry_inc;
   logic [SEAT_W-1:0]   seats;
   logic                seat_err;
   logic                accepted, seat_ok, seat_rej, seat_valid;
   logic                expired;

   assign seat_valid = (bif.seat_req != '0)
                    && (bif.seat_req <= SEAT_W'(MAX_SEATS))
                    && (bif.seat_req <= bif.seats_avail);
   assign retry_inc  = retry + RETRY_W'(1);

   booking_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
      .clk     (clk),
      .rst     (rst),
      .clr     ((state_nxt != state) || accepted),
      .en      (is_active(state)),
      .expired (expired)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         retry    <= '0;
         seats    <= '0;
         seat_err <= 1'b0;
      end else begin
         state    <= state_nxt;
         retry    <= retry_nxt;
         seat_err <= seat_rej;
         if (seat_ok) begin
            seats <= bif.seat_req;
         end else if ((state_nxt == S_ABORT) ||
                      ((state_nxt == S_SELECT_SEAT) && (state != S_SELECT_SEAT))) begin
            seats <= '0;
         end
      end
   end

   // Next state; priority in active steps is cancel > timeout > back > payment > nxt.
   always_comb begin
      state_nxt = state;
      retry_nxt = retry;
      accepted  = 1'b0;
      seat_ok   = 1'b0;
      seat_rej  = 1'b0;
      case (state)
         S_IDLE: begin
            if (bif.nxt) state_nxt = S_OPEN_APP;
         end
         S_DONE, S_ABORT: begin
            state_nxt = S_IDLE;
         end
         default: begin
            if (bif.cancel) begin
               state_nxt = S_ABORT;
            end else if (expired) begin
               state_nxt = S_ABORT;
            end else if (bif.back) begin
               accepted  = 1'b1;
               state_nxt = (state == S_OPEN_APP) ? S_IDLE : state_t'(state - 4'd1);
            end else if ((state == S_PAYMENT) && (bif.pay_ok || bif.pay_fail)) begin
               accepted = 1'b1;
               if (bif.pay_ok) begin
                  state_nxt = S_DONE;
               end else if (retry_inc == RETRY_W'(MAX_RETRY)) begin
                  state_nxt = S_ABORT;
               end else begin
                  retry_nxt = retry_inc;
               end
            end else if (bif.nxt && (state != S_PAYMENT)) begin
               accepted = 1'b1;
               if (state == S_SELECT_SEAT) begin
                  if (seat_valid) begin
                     seat_ok   = 1'b1;
                     state_nxt = S_BOARDING;
                  end else begin
                     seat_rej  = 1'b1;
                  end
               end else begin
                  state_nxt = state_t'(state + 4'd1);
               end
            end
         end
      endcase
      if (state_nxt != S_PAYMENT) retry_nxt = '0;
   end

   assign bif.state        = state;
   assign bif.busy         = (state != S_IDLE);
   assign bif.seats_booked = seats;
   assign bif.seat_err     = seat_err;
   assign bif.booked       = (state == S_DONE);
   assign bif.aborted      = (state == S_ABORT);

endmodule

// File: tb/tb_bus_booking_ctrl.sv
// Directed and randomized bench for bus_booking_ctrl against a cycle-level reference model.
module tb_bus_booking_ctrl;

   localparam int unsigned TO = 8;
   localparam int unsigned MS = 6;
   localparam int unsigned SW = 4;
   localparam int unsigned MR = 3;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   bus_booking_ctrl_if #(.SEAT_W(SW)) bif ();

   bus_booking_ctrl #(
      .TIMEOUT_CYC (TO),
      .MAX_SEATS   (MS),
      .SEAT_W      (SW),
      .MAX_RETRY   (MR)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bif (bif.slave)
   );

   int errors = 0;
   int checks = 0;

   // Reference model: step number, booked seats, payment failures, idle cycles in step.
   int m_st, m_seats, m_retry, m_idle, m_serr;

   task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
      checks++;
      assert (o === e) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, o, e);
      end
   endtask

   task automatic model_step(input bit r, input bit n, input bit b, input bit c,
                             input int req, input int av, input bit ok, input bit fl);
      int  nst;
      bit  acc;
      bit  active;
      if (r) begin
         m_st = 0; m_seats = 0; m_retry = 0; m_idle = 0; m_serr = 0;
         return;
      end
      nst    = m_st;
      acc    = 1'b0;
      active = (m_st >= 1) && (m_st <= 8);
      m_serr = 0;
      if (m_st == 0) begin
         if (n) nst = 1;
      end else if (!active) begin
         nst = 0;
      end else if (c || (m_idle >= int'(TO) - 1)) begin
         nst = 10;
      end else if (b) begin
         acc = 1'b1;
         nst = m_st - 1;
      end else if (m_st == 8 && (ok || fl)) begin
         acc = 1'b1;
         if (ok) nst = 9;
         else begin
            m_retry++;
            if (m_retry == int'(MR)) nst = 10;
         end
      end else if (n && m_st != 8) begin
         acc = 1'b1;
         if (m_st == 5) begin
            if (req >= 1 && req <= int'(MS) && req <= av) begin
               m_seats = req;
               nst     = 6;
            end else m_serr = 1;
         end else nst = m_st + 1;
      end
      if (nst != m_st || acc) m_idle = 0;
      else if (active)        m_idle++;
      if (nst != 8) m_retry = 0;
      if (nst == 10 || (nst == 5 && m_st != 5)) m_seats = 0;
      m_st = nst;
   endtask

   task automatic cyc(input bit r, input bit n, input bit b, input bit c,
                      input int req, input int av, input bit ok, input bit fl);
      @(negedge clk);
      rst             = r;
      bif.nxt         = n;
      bif.back        = b;
      bif.cancel      = c;
      bif.seat_req    = SW'(req);
      bif.seats_avail = SW'(av);
      bif.pay_ok      = ok;
      bif.pay_fail    = fl;
      @(posedge clk);
      model_step(r, n, b, c, req, av, ok, fl);
      #1;
      chk("state",        32'(bif.state),        32'(m_st));
      chk("busy",         32'(bif.busy),         32'(m_st != 0));
      chk("seats_booked", 32'(bif.seats_booked), 32'(m_seats));
      chk("seat_err",     32'(bif.seat_err),     32'(m_serr));
      chk("booked",       32'(bif.booked),       32'(m_st == 9));
      chk("aborted",      32'(bif.aborted),      32'(m_st == 10));
   endtask

   task automatic idle(input int k);
      for (int i = 0; i < k; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic nx(input int k, input int req, input int av);
      for (int i = 0; i < k; i++) cyc(0, 1, 0, 0, req, av, 0, 0);
   endtask

   initial begin
      rst = 1'b1;
      bif.nxt = 0; bif.back = 0; bif.cancel = 0; bif.pay_ok = 0; bif.pay_fail = 0;
      bif.seat_req = '0; bif.seats_avail = '0;

      // Reset
      cyc(1, 0, 0, 0, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0, 0, 0, 0);
      chk("reset_state", 32'(bif.state), 32'd0);

      // Happy path
      nx(8, 2, 10);
      chk("happy_payment", 32'(bif.state), 32'd8);
      cyc(0, 0, 0, 0, 0, 0, 1, 0);
      chk("happy_booked", 32'(bif.booked), 32'd1);
      chk("happy_seats", 32'(bif.seats_booked), 32'd2);
      idle(2);

      // Seat reject then accept, back handling
      nx(5, 2, 10);
      cyc(0, 1, 0, 0, 0, 10, 0, 0);
      cyc(0, 1, 0, 0, 7, 10, 0, 0);
      cyc(0, 1, 0, 0, 3, 2, 0, 0);
      idle(1);
      chk("seat_hold", 32'(bif.state), 32'd5);
      cyc(0, 1, 0, 0, 2, 10, 0, 0);
      nx(1, 0, 0);
      cyc(0, 0, 1, 0, 0, 0, 0, 0);
      chk("back_coupon", 32'(bif.state), 32'd6);
      nx(1, 0, 0);
      cyc(0, 1, 1, 0, 0, 0, 0, 0);
      chk("back_wins", 32'(bif.state), 32'd6);
      cyc(0, 0, 0, 1, 0, 0, 0, 0);
      idle(1);

      // Cancel at FILTER
      nx(3, 0, 0);
      cyc(0, 0, 0, 1, 0, 0, 0, 0);
      chk("cancel_abort", 32'(bif.aborted), 32'd1);
      idle(1);

      // Payment retries
      nx(8, 3, 5);
      cyc(0, 0, 0, 0, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 0, 0, 0, 1);
      chk("retry_stay", 32'(bif.state), 32'd8);
      cyc(0, 0, 0, 0, 0, 0, 0, 1);
      chk("retry_abort", 32'(bif.state), 32'd10);
      idle(1);
      nx(8, 1, 1);
      cyc(0, 0, 0, 0, 0, 0, 1, 1);
      chk("ok_wins", 32'(bif.state), 32'd9);
      idle(1);

      // Inactivity timeout
      nx(2, 0, 0);
      idle(7);
      chk("to_pending", 32'(bif.state), 32'd2);
      idle(1);
      chk("to_abort", 32'(bif.state), 32'd10);
      idle(1);
      nx(2, 0, 0);
      idle(5);
      nx(1, 0, 0);
      idle(7);
      chk("to_restart", 32'(bif.state), 32'd3);
      idle(2);

      // Reset in PAYMENT
      nx(8, 4, 6);
      cyc(1, 0, 0, 0, 0, 0, 0, 0);
      chk("rst_mid", 32'(bif.state), 32'd0);
      chk("rst_seats", 32'(bif.seats_booked), 32'd0);
      cyc(0, 0, 0, 0, 0, 0, 0, 0);

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         cyc($urandom_range(0, 199) == 0, $urandom_range(0, 3) == 0,
             $urandom_range(0, 9) == 0,   $urandom_range(0, 49) == 0,
             int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
             $urandom_range(0, 9) == 0,   $urandom_range(0, 5) == 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
